// File: rtl/noc_pkg.sv
// Shared NoC types and default sizing constants for the local network interface.
package noc_pkg;

  localparam int unsigned FLIT_W       = 16;
  localparam int unsigned TX_DEPTH_DEF = 4;
  localparam int unsigned RX_DEPTH_DEF = 4;
  localparam int unsigned CREDITS_DEF  = 4;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/noc_fifo.sv
// Synchronous flit FIFO with async active-low reset; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module noc_fifo
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH = TX_DEPTH_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  flit_t din,
  output flit_t dout,
  output logic  full,
  output logic  empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  flit_t       mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/noc_local_ni.sv
// Local network interface: credit-based TX injection and RX ejection FIFOs.
// Optional sticky protocol-error flag enabled by `define NOC_NI_ERR_EN.
module noc_local_ni
  import noc_pkg::*;
#(
  parameter int unsigned TX_DEPTH = TX_DEPTH_DEF,
  parameter int unsigned RX_DEPTH = RX_DEPTH_DEF,
  parameter int unsigned CREDITS  = CREDITS_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  flit_t core_tx_flit,
  input  logic  core_tx_valid,
  output logic  core_tx_ready,
  output flit_t flit_o,
  output logic  valid_o,
  input  logic  incr_i,
  input  flit_t flit_i,
  input  logic  valid_i,
  output logic  incr_o,
  output flit_t core_rx_flit,
  output logic  core_rx_valid,
  input  logic  core_rx_ready
`ifdef NOC_NI_ERR_EN
  ,
  output logic  err
`endif
);

  localparam int unsigned   CW       = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  logic          tx_full;
  logic          tx_empty;
  logic          rx_full;
  logic          rx_empty;
  logic          send;
  logic          rx_pop;
  flit_t         tx_head;
  logic [CW-1:0] credit;

  assign core_tx_ready = !tx_full;
  assign send          = !tx_empty && (credit != '0);
  assign core_rx_valid = !rx_empty;
  assign rx_pop        = core_rx_valid && core_rx_ready;

  noc_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (core_tx_valid && core_tx_ready),
    .pop   (send),
    .din   (core_tx_flit),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  noc_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (valid_i),
    .pop   (rx_pop),
    .din   (flit_i),
    .dout  (core_rx_flit),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o <= 1'b0;
      flit_o  <= '0;
      incr_o  <= 1'b0;
      credit  <= CRED_MAX;
    end else begin
      valid_o <= send;
      if (send) flit_o <= tx_head;
      incr_o  <= rx_pop;
      // Simultaneous send and return cancel; a return at full credit is ignored.
      unique case ({send, incr_i})
        2'b10:   credit <= credit - CW'(1);
        2'b01:   if (credit != CRED_MAX) credit <= credit + CW'(1);
        default: credit <= credit;
      endcase
    end
  end

`ifdef NOC_NI_ERR_EN
  logic incr_lost;
  logic rx_drop;

  assign incr_lost = incr_i && !send && (credit == CRED_MAX);
  assign rx_drop   = valid_i && rx_full && !rx_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        err <= 1'b0;
    else if (incr_lost || rx_drop)   err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_noc_local_ni.sv
// Self-checking bench for noc_local_ni: queue-based reference model plus
// directed literal scenarios and randomized traffic.
module tb_noc_local_ni;
  import noc_pkg::*;

  localparam int unsigned TXD = 4;
  localparam int unsigned RXD = 4;
  localparam int unsigned CRD = 4;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  flit_t core_tx_flit = '0;
  logic  core_tx_valid = 1'b0;
  logic  core_tx_ready;
  flit_t flit_o;
  logic  valid_o;
  logic  incr_i = 1'b0;
  flit_t flit_i = '0;
  logic  valid_i = 1'b0;
  logic  incr_o;
  flit_t core_rx_flit;
  logic  core_rx_valid;
  logic  core_rx_ready = 1'b0;
`ifdef NOC_NI_ERR_EN
  logic  err;
`endif

  int vectors = 0;
  int miscompares = 0;

  noc_local_ni #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .CREDITS(CRD)) dut (
    .clk           (clk),
    .rst           (rst),
    .core_tx_flit  (core_tx_flit),
    .core_tx_valid (core_tx_valid),
    .core_tx_ready (core_tx_ready),
    .flit_o        (flit_o),
    .valid_o       (valid_o),
    .incr_i        (incr_i),
    .flit_i        (flit_i),
    .valid_i       (valid_i),
    .incr_o        (incr_o),
    .core_rx_flit  (core_rx_flit),
    .core_rx_valid (core_rx_valid),
    .core_rx_ready (core_rx_ready)
`ifdef NOC_NI_ERR_EN
    ,
    .err           (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: queues and an integer credit pool.
  flit_t tx_q[$];
  flit_t rx_q[$];
  int    credit_m = CRD;
  logic  m_valid_o = 1'b0;
  flit_t m_flit_o = '0;
  logic  m_incr_o = 1'b0;
  logic  m_err = 1'b0;

  always @(posedge clk or negedge rst) begin
    bit tx_can_push, send, pop, rx_has_room;
    if (!rst) begin
      tx_q.delete();
      rx_q.delete();
      credit_m  = CRD;
      m_valid_o = 1'b0;
      m_flit_o  = '0;
      m_incr_o  = 1'b0;
      m_err     = 1'b0;
    end else begin
      tx_can_push = tx_q.size() < TXD;
      send        = tx_q.size() > 0 && credit_m > 0;
      if (incr_i && !send && credit_m == CRD) m_err = 1'b1;
      if (incr_i && !(credit_m == CRD && !send)) credit_m++;
      if (send) begin
        credit_m--;
        m_flit_o = tx_q.pop_front();
      end
      m_valid_o = send;
      if (core_tx_valid && tx_can_push) tx_q.push_back(core_tx_flit);

      pop         = rx_q.size() > 0 && core_rx_ready;
      rx_has_room = rx_q.size() < RXD || pop;
      if (pop) void'(rx_q.pop_front());
      if (valid_i) begin
        if (rx_has_room) rx_q.push_back(flit_i);
        else m_err = 1'b1;
      end
      m_incr_o = pop;
    end
  end

  always @(negedge clk) begin
    chk("valid_o", {15'b0, valid_o}, {15'b0, m_valid_o});
    chk("flit_o", flit_o, m_flit_o);
    chk("incr_o", {15'b0, incr_o}, {15'b0, m_incr_o});
    chk("core_tx_ready", {15'b0, core_tx_ready}, {15'b0, tx_q.size() < TXD});
    chk("core_rx_valid", {15'b0, core_rx_valid}, {15'b0, rx_q.size() > 0});
    chk("core_rx_flit", core_rx_flit, (rx_q.size() > 0) ? rx_q[0] : 16'h0000);
`ifdef NOC_NI_ERR_EN
    chk("err", {15'b0, err}, {15'b0, m_err});
`endif
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic lit_tx(input string name, input logic v, input flit_t f);
    chk({name, "_v"}, {15'b0, valid_o}, {15'b0, v});
    if (v) chk({name, "_f"}, flit_o, f);
  endtask

  initial begin
    flit_t seq35 [5];
    seq35 = '{16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005};

    // Reset with stimulus active: nothing may be accepted.
    core_tx_valid = 1'b1; core_tx_flit = 16'hDEAD; valid_i = 1'b1; flit_i = 16'hBEEF;
    step(); step();
    chk("rst_tx_ready", {15'b0, core_tx_ready}, 16'h1);
    chk("rst_rx_valid", {15'b0, core_rx_valid}, 16'h0);
    chk("rst_rx_flit", core_rx_flit, 16'h0000);
    chk("rst_flit_o", flit_o, 16'h0000);
    core_tx_valid = 1'b0; valid_i = 1'b0;
    rst = 1'b1;
    step();

    // Return at full credit is ignored (saturates).
    incr_i = 1'b1; step(); incr_i = 1'b0; step();
`ifdef NOC_NI_ERR_EN
    chk("err_incr", {15'b0, err}, 16'h1);
`endif

    // Five flits, four credits: fifth waits for one return.
    core_tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      core_tx_flit = seq35[i];
      step();
      if (i == 0) lit_tx("r35_first", 1'b0, '0);
      else        lit_tx("r35_burst", 1'b1, seq35[i-1]);
    end
    core_tx_valid = 1'b0;
    step(); lit_tx("r35_stall0", 1'b0, '0);
    step(); lit_tx("r35_stall1", 1'b0, '0);
    incr_i = 1'b1; step(); lit_tx("r35_incr", 1'b0, '0);
    incr_i = 1'b0; step(); lit_tx("r35_last", 1'b1, 16'h1005);
    step(); lit_tx("r35_done", 1'b0, '0);

    // Credit 2 with send and return in the same cycle.
    incr_i = 1'b1; step(); step(); incr_i = 1'b0;
    core_tx_valid = 1'b1; core_tx_flit = 16'hB001; step();
    core_tx_flit = 16'hB002; incr_i = 1'b1; step(); lit_tx("r36_a", 1'b1, 16'hB001);
    core_tx_flit = 16'hB003; incr_i = 1'b0; step(); lit_tx("r36_b", 1'b1, 16'hB002);
    core_tx_valid = 1'b0; step(); lit_tx("r36_c", 1'b1, 16'hB003);
    core_tx_valid = 1'b1; core_tx_flit = 16'hB004; step(); core_tx_valid = 1'b0;
    step(); lit_tx("r36_zero", 1'b0, '0);
    incr_i = 1'b1; step(); incr_i = 1'b0; step(); lit_tx("r36_d", 1'b1, 16'hB004);
    incr_i = 1'b1; for (int i = 0; i < 4; i++) step(); incr_i = 1'b0;

    // Drain credits, then fill the TX FIFO with no credit.
    core_tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin core_tx_flit = 16'hC001 + 16'(i); step(); end
    for (int i = 0; i < 4; i++) begin core_tx_flit = 16'hD001 + 16'(i); step(); end
    chk("r37_full", {15'b0, core_tx_ready}, 16'h0);
    core_tx_flit = 16'hD005; step(); step();
    chk("r37_held", {15'b0, core_tx_ready}, 16'h0);
    core_tx_valid = 1'b0; incr_i = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("r37_drained", {15'b0, core_tx_ready}, 16'h1);
    for (int i = 0; i < 20 && credit_m != CRD; i++) step();
    incr_i = 1'b0;
    chk("r37_credit_bound", credit_m[15:0], 16'(CRD));
    step();

    // RX single flit, pop and credit return.
    valid_i = 1'b1; flit_i = 16'hA5A5; step(); valid_i = 1'b0;
    chk("r38_valid", {15'b0, core_rx_valid}, 16'h1);
    chk("r38_flit", core_rx_flit, 16'hA5A5);
    chk("r38_noincr", {15'b0, incr_o}, 16'h0);
    step(); chk("r38_noincr2", {15'b0, incr_o}, 16'h0);
    core_rx_ready = 1'b1; step(); core_rx_ready = 1'b0;
    chk("r38_incr", {15'b0, incr_o}, 16'h1);
    step(); chk("r38_incr_off", {15'b0, incr_o}, 16'h0);

    // RX overflow: fifth flit dropped.
    valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin flit_i = 16'hE001 + 16'(i); step(); end
    valid_i = 1'b0;
`ifdef NOC_NI_ERR_EN
    chk("r39_err_drop", {15'b0, err}, 16'h1);
`endif
    core_rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("r39_order", core_rx_flit, 16'hE001 + 16'(i));
      step();
    end
    chk("r39_empty", {15'b0, core_rx_valid}, 16'h0);
    core_rx_ready = 1'b0;

    // Reset mid-operation with three flits queued and no credit.
    core_tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin core_tx_flit = 16'hF001 + 16'(i); step(); end
    for (int i = 0; i < 3; i++) begin core_tx_flit = 16'hF101 + 16'(i); step(); end
    core_tx_valid = 1'b0; valid_i = 1'b1; flit_i = 16'h7777; step(); valid_i = 1'b0;
    rst = 1'b0; #1;
    chk("r40_valid_o", {15'b0, valid_o}, 16'h0);
    chk("r40_incr_o", {15'b0, incr_o}, 16'h0);
`ifdef NOC_NI_ERR_EN
    chk("r40_err", {15'b0, err}, 16'h0);
`endif
    step(); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      lit_tx("r40_quiet", 1'b0, '0);
      chk("r40_rx_empty", {15'b0, core_rx_valid}, 16'h0);
    end
    core_tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      core_tx_flit = 16'h4001 + 16'(i);
      step();
      if (i > 0) lit_tx("r40_credit4", 1'b1, 16'h4001 + 16'(i - 1));
    end
    core_tx_valid = 1'b0;
    step(); lit_tx("r40_credit0", 1'b0, '0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      core_tx_valid = 1'($urandom_range(0, 1));
      core_tx_flit  = 16'($urandom);
      incr_i        = ($urandom_range(0, 9) < 3);
      valid_i       = 1'($urandom_range(0, 1));
      flit_i        = 16'($urandom);
      core_rx_ready = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0; step(); rst = 1'b1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
